// File: rtl/pipeline_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_control_pkg
//  Description : Shared definitions for the pipeline control block. The state
//                encodings are also used by trace/debug logic, so their values
//                are fixed and must not be renumbered.
//  Contents    : c_st_run, c_st_drain, c_st_halted (2-bit state encodings)
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_control_pkg;

    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_drain  = 2'd1;
    localparam logic [1:0] c_st_halted = 2'd2;

endpackage : pipeline_control_pkg
`default_nettype wire

// File: rtl/pipeline_control_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : WIDTH-bit up counter that sticks at all-ones instead of
//                wrapping. Synchronous active-low clear has priority.
//  Ports       : clk      - clock
//                i_clr_n  - synchronous clear, active low
//                i_inc    - increment enable
//                o_count  - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_control.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_control
//  Description : Converts load-use stall, EX mispredict, data-memory busy and
//                halt requests into per-stage write-enable / bubble / flush
//                controls for a 5-stage pipeline. Owns the halt drain FSM and
//                saturating cycle / stall / flush performance counters.
//  Ports       : clk, reset (sync, active low)
//                is_stall, ex_mispredict, dmem_busy, id_is_halt  - requests
//                pc_write, if_id_write, if_id_flush, id_ex_write,
//                id_ex_bubble, ex_mem_write, mem_wb_write        - controls
//                is_halted                                        - status
//                cycle_count, stall_count, flush_count            - counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_stall,
    input  logic                 ex_mispredict,
    input  logic                 dmem_busy,
    input  logic                 id_is_halt,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_write,
    output logic                 id_ex_bubble,
    output logic                 ex_mem_write,
    output logic                 mem_wb_write,
    output logic                 is_halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DCW-1:0] c_drain_load = DCW'(DRAIN_CYCLES);
    localparam logic [DCW-1:0] c_drain_one  = DCW'(1);

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [DCW-1:0] r_drain_cnt;
    logic [DCW-1:0] w_drain_nxt;
    logic           w_cycle_inc;
    logic           w_stall_inc;
    logic           w_flush_inc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_st_run;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain_cnt;
        w_cycle_inc  = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;

        if (!reset) begin
            // Hold every register and force NOPs into the front stages.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else begin
            case (r_state)
                c_st_run: begin
                    w_cycle_inc = 1'b1;
                    if (dmem_busy) begin
                        // Whole-pipeline freeze; everything else waits.
                        w_stall_inc = 1'b1;
                    end else if (ex_mispredict) begin
                        // ID holds a wrong-path instruction, so its stall or
                        // halt request is discarded along with it.
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_write  = 1'b1;
                        id_ex_bubble = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                        w_flush_inc  = 1'b1;
                    end else if (is_stall) begin
                        id_ex_write  = 1'b1;
                        id_ex_bubble = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                        w_stall_inc  = 1'b1;
                    end else if (id_is_halt) begin
                        // Halt moves on to EX; fetch stops right away.
                        if_id_write  = 1'b1;
                        id_ex_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                        w_state_nxt  = c_st_drain;
                        w_drain_nxt  = c_drain_load;
                    end else begin
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        id_ex_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                    end
                end
                c_st_drain: begin
                    w_cycle_inc = 1'b1;
                    if (dmem_busy) begin
                        w_stall_inc = 1'b1;
                    end else begin
                        // Keep NOPs flowing in behind the halt until it retires.
                        if_id_write  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                        w_drain_nxt  = r_drain_cnt - c_drain_one;
                        if (r_drain_cnt == c_drain_one) begin
                            w_state_nxt = c_st_halted;
                        end
                    end
                end
                c_st_halted: begin
                    w_state_nxt = c_st_halted;
                end
                default: begin
                    w_state_nxt = c_st_run;
                end
            endcase
        end
    end

    assign is_halted = (r_state == c_st_halted);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk     (clk),
        .i_clr_n (reset),
        .i_inc   (w_cycle_inc),
        .o_count (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .i_clr_n (reset),
        .i_inc   (w_stall_inc),
        .o_count (stall_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .i_clr_n (reset),
        .i_inc   (w_flush_inc),
        .o_count (flush_count)
    );

endmodule : pipeline_control
`default_nettype wire

// File: tb/tb_pipeline_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_control
//  Description : Directed self-checking bench for pipeline_control. Counters
//                are 8 bits wide so saturation is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_control;

    localparam int CW = 8;

    // Control vector order: pc, if_id_w, if_id_flush, id_ex_w, id_ex_bubble,
    // ex_mem_w, mem_wb_w
    localparam logic [6:0] c_rst_ctl   = 7'b0010100;
    localparam logic [6:0] c_free_ctl  = 7'b1101011;
    localparam logic [6:0] c_stall_ctl = 7'b0001111;
    localparam logic [6:0] c_flush_ctl = 7'b1111111;
    localparam logic [6:0] c_halt_ctl  = 7'b0101011;
    localparam logic [6:0] c_drain_ctl = 7'b0111011;
    localparam logic [6:0] c_zero_ctl  = 7'b0000000;

    logic clk = 1'b0;
    logic reset, is_stall, ex_mispredict, dmem_busy, id_is_halt;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
    logic ex_mem_write, mem_wb_write, is_halted;
    logic [CW-1:0] cycle_count, stall_count, flush_count;
    logic [6:0] ctl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write,
                  id_ex_bubble, ex_mem_write, mem_wb_write};

    pipeline_control #(.CNT_WIDTH(CW), .DRAIN_CYCLES(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .is_stall      (is_stall),
        .ex_mispredict (ex_mispredict),
        .dmem_busy     (dmem_busy),
        .id_is_halt    (id_is_halt),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_write   (id_ex_write),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_write  (ex_mem_write),
        .mem_wb_write  (mem_wb_write),
        .is_halted     (is_halted),
        .cycle_count   (cycle_count),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge, then 1 more unit of settle before checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic m, input logic d, input logic h);
        is_stall = s; ex_mispredict = m; dmem_busy = d; id_is_halt = h;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_in(0, 0, 0, 0);
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_in(0, 0, 0, 0);
        n_cmp++; if (ctl !== c_rst_ctl) begin n_err++; $display("FAIL reset_ctl: got %b expected %b", ctl, c_rst_ctl); end
        tick();
        n_cmp++; if (is_halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b expected 0", is_halted); end
        n_cmp++; if ({cycle_count, stall_count, flush_count} !== '0) begin n_err++; $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", cycle_count, stall_count, flush_count); end
        reset = 1'b1;
        #1;
        n_cmp++; if (ctl !== c_free_ctl) begin n_err++; $display("FAIL first_free_ctl: got %b expected %b", ctl, c_free_ctl); end
    endtask

    task automatic test_load_use();
        set_in(1, 0, 0, 0);
        n_cmp++; if (ctl !== c_stall_ctl) begin n_err++; $display("FAIL load_use_ctl: got %b expected %b", ctl, c_stall_ctl); end
        n_cmp++; if (stall_count !== 8'd0) begin n_err++; $display("FAIL load_use_cnt_before: got %0d expected 0", stall_count); end
        tick();
        set_in(0, 0, 0, 0);
        n_cmp++; if (stall_count !== 8'd1) begin n_err++; $display("FAIL load_use_cnt_after: got %0d expected 1", stall_count); end
        n_cmp++; if (ctl !== c_free_ctl) begin n_err++; $display("FAIL load_use_release: got %b expected %b", ctl, c_free_ctl); end
    endtask

    task automatic test_mispredict_stall();
        set_in(1, 1, 0, 0);
        n_cmp++; if (ctl !== c_flush_ctl) begin n_err++; $display("FAIL mispredict_ctl: got %b expected %b", ctl, c_flush_ctl); end
        tick();
        set_in(0, 0, 0, 0);
        n_cmp++; if (flush_count !== 8'd1) begin n_err++; $display("FAIL mispredict_flush_cnt: got %0d expected 1", flush_count); end
        n_cmp++; if (stall_count !== 8'd1) begin n_err++; $display("FAIL mispredict_stall_cnt: got %0d expected 1", stall_count); end
    endtask

    task automatic test_dmem_freeze();
        set_in(0, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (ctl !== c_zero_ctl) begin n_err++; $display("FAIL freeze_ctl[%0d]: got %b expected %b", i, ctl, c_zero_ctl); end
            tick();
        end
        n_cmp++; if (stall_count !== 8'd3) begin n_err++; $display("FAIL freeze_stall_cnt: got %0d expected 3", stall_count); end
        n_cmp++; if (flush_count !== 8'd1) begin n_err++; $display("FAIL freeze_flush_cnt: got %0d expected 1", flush_count); end
        set_in(0, 1, 0, 0);
        n_cmp++; if (ctl !== c_flush_ctl) begin n_err++; $display("FAIL freeze_release_ctl: got %b expected %b", ctl, c_flush_ctl); end
        tick();
        set_in(0, 0, 0, 0);
        n_cmp++; if (flush_count !== 8'd2) begin n_err++; $display("FAIL freeze_release_flush_cnt: got %0d expected 2", flush_count); end
    endtask

    // Halt at N, dmem busy during the second drain cycle: 4 drain cycles.
    task automatic test_halt_drain();
        do_reset();
        set_in(0, 0, 0, 1);
        n_cmp++; if (ctl !== c_halt_ctl) begin n_err++; $display("FAIL halt_ctl: got %b expected %b", ctl, c_halt_ctl); end
        tick();
        set_in(0, 0, 0, 0);
        n_cmp++; if (ctl !== c_drain_ctl) begin n_err++; $display("FAIL drain1_ctl: got %b expected %b", ctl, c_drain_ctl); end
        tick();
        set_in(0, 0, 1, 0);
        n_cmp++; if (ctl !== c_zero_ctl) begin n_err++; $display("FAIL drain_freeze_ctl: got %b expected %b", ctl, c_zero_ctl); end
        tick();
        set_in(0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (ctl !== c_drain_ctl || is_halted !== 1'b0) begin n_err++; $display("FAIL drain_tail[%0d]: got %b/%b expected %b/0", i, ctl, is_halted, c_drain_ctl); end
            tick();
        end
        n_cmp++; if (is_halted !== 1'b1) begin n_err++; $display("FAIL halted_set: got %b expected 1", is_halted); end
        n_cmp++; if (cycle_count !== 8'd5 || stall_count !== 8'd1 || flush_count !== 8'd0) begin n_err++; $display("FAIL drain_counts: got %0d/%0d/%0d expected 5/1/0", cycle_count, stall_count, flush_count); end
        set_in(1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (ctl !== c_zero_ctl || is_halted !== 1'b1) begin n_err++; $display("FAIL halted_hold[%0d]: got %b/%b expected %b/1", i, ctl, is_halted, c_zero_ctl); end
            tick();
        end
        n_cmp++; if (cycle_count !== 8'd5 || stall_count !== 8'd1) begin n_err++; $display("FAIL halted_counts: got %0d/%0d expected 5/1", cycle_count, stall_count); end
        set_in(0, 0, 0, 0);
    endtask

    task automatic test_reset_from_halted();
        reset = 1'b0;
        #1;
        n_cmp++; if (ctl !== c_rst_ctl) begin n_err++; $display("FAIL halted_reset_ctl: got %b expected %b", ctl, c_rst_ctl); end
        tick();
        n_cmp++; if (is_halted !== 1'b0 || {cycle_count, stall_count, flush_count} !== '0) begin n_err++; $display("FAIL halted_reset_state: got %b %0d/%0d/%0d expected 0 0/0/0", is_halted, cycle_count, stall_count, flush_count); end
        reset = 1'b1;
        #1;
        n_cmp++; if (ctl !== c_free_ctl) begin n_err++; $display("FAIL halted_reset_free: got %b expected %b", ctl, c_free_ctl); end
        tick();
        n_cmp++; if (cycle_count !== 8'd1) begin n_err++; $display("FAIL halted_reset_cycle: got %0d expected 1", cycle_count); end
    endtask

    // Unobstructed drain: exactly DRAIN_CYCLES cycles, halted from N+4.
    task automatic test_halt_plain();
        do_reset();
        set_in(0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (ctl !== c_drain_ctl || is_halted !== 1'b0) begin n_err++; $display("FAIL plain_drain[%0d]: got %b/%b expected %b/0", i, ctl, is_halted, c_drain_ctl); end
            tick();
        end
        n_cmp++; if (is_halted !== 1'b1 || cycle_count !== 8'd4) begin n_err++; $display("FAIL plain_halted: got %b/%0d expected 1/4", is_halted, cycle_count); end
    endtask

    task automatic test_halt_cancel();
        do_reset();
        set_in(0, 1, 0, 1);
        n_cmp++; if (ctl !== c_flush_ctl) begin n_err++; $display("FAIL cancel_ctl: got %b expected %b", ctl, c_flush_ctl); end
        tick();
        set_in(0, 0, 0, 0);
        n_cmp++; if (ctl !== c_free_ctl || flush_count !== 8'd1) begin n_err++; $display("FAIL cancel_run: got %b/%0d expected %b/1", ctl, flush_count, c_free_ctl); end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (is_halted !== 1'b0 || ctl !== c_free_ctl) begin n_err++; $display("FAIL cancel_no_halt: got %b/%b expected 0/%b", is_halted, ctl, c_free_ctl); end
    endtask

    task automatic test_reset_mid_drain();
        set_in(0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0);
        tick();
        do_reset();
        n_cmp++; if (ctl !== c_free_ctl || is_halted !== 1'b0) begin n_err++; $display("FAIL mid_drain_reset: got %b/%b expected %b/0", ctl, is_halted, c_free_ctl); end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (is_halted !== 1'b0 || cycle_count !== 8'd4) begin n_err++; $display("FAIL mid_drain_run: got %b/%0d expected 0/4", is_halted, cycle_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(0, 0, 1, 0);
        for (int i = 0; i < 300; i++) tick();
        n_cmp++; if (cycle_count !== 8'hFF || stall_count !== 8'hFF) begin n_err++; $display("FAIL saturate: got %0d/%0d expected 255/255", cycle_count, stall_count); end
        set_in(0, 1, 0, 0);
        for (int i = 0; i < 260; i++) tick();
        n_cmp++; if (flush_count !== 8'hFF || cycle_count !== 8'hFF) begin n_err++; $display("FAIL saturate_flush: got %0d/%0d expected 255/255", flush_count, cycle_count); end
        set_in(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        is_stall = 1'b0; ex_mispredict = 1'b0; dmem_busy = 1'b0; id_is_halt = 1'b0;
        tick();
        test_reset();
        test_load_use();
        test_mispredict_stall();
        test_dmem_freeze();
        test_halt_drain();
        test_reset_from_halted();
        test_halt_plain();
        test_halt_cancel();
        test_reset_mid_drain();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipeline_control
`default_nettype wire
